cache_mem_responder: RTL and testbench

//  Memory-side responder for the cache's memory port (mwrite_en/maddr/mdata/mout).
//  - Word RAM: combinational read, posedge write; meets the cache's same-cycle fill timing.
//  - Burst tracker FSM: checks every fill/write-back is one whole, in-order line.
//  - Flags protocol violations; optional per-line traffic counters.
//  - Sits between the cache instance and the top level; a loader port preloads programs.

---
 rtl/cache_mem_responder.sv | 130 +++++++++++++
 tb/tb_cache_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: word RAM plus line-burst checker for the cache memory port; mout is combinational, line_done pulses the cycle after a line's last word.
// No backpressure: every access is accepted and out-of-order traffic is flagged. Define MEM_STATS_EN to add fill_cnt/wb_cnt.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_WIDTH = `CACHE_B,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mactive,
  input  logic                  mwrite_en,
  input  logic [31:0]           maddr,
  input  logic [31:0]           mdata,
  output logic [31:0]           mout,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  line_done,
  output logic                  line_is_wb,
  output logic                  protocol_err
`ifdef MEM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  fill_cnt,
  output logic [CNT_WIDTH-1:0]  wb_cnt
`endif
);

  localparam int WORDS = 2 ** (LINE_WIDTH - 2);
  localparam int CW    = (LINE_WIDTH > 2) ? LINE_WIDTH - 2 : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WB} state_t;

  state_t                state;
  logic [31:0]           base;
  logic [CW-1:0]         cnt;

  logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
  logic [ADDR_WIDTH-1:0] w;
  logic                  in_range;
  logic                  cache_we;
  logic                  collide;
  logic [CW-1:0]         off;
  logic [31:0]           line_a;
  logic                  busy;
  logic                  expected;
  logic                  restart;
  logic                  burst_end;
  logic                  single_end;
  logic                  done_now;
  logic                  done_wb;
  logic                  err_set;

  assign w        = maddr[ADDR_WIDTH+1:2];
  assign in_range = (maddr[31:ADDR_WIDTH+2] == '0);
  assign mout     = in_range ? mem[w] : 32'd0;
  assign cache_we = mactive & mwrite_en & in_range & ~load_en;
  assign collide  = load_en & mactive & mwrite_en & in_range;

  // Loader has priority; the RAM itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_en)       mem[load_addr] <= load_data;
    else if (cache_we) mem[w]         <= mdata;
  end

  assign off      = CW'((maddr >> 2) & 32'(WORDS - 1));
  assign line_a   = maddr >> LINE_WIDTH;
  assign busy     = (state != IDLE);
  assign expected = busy && (line_a == base) && (off == cnt) && (mwrite_en == (state == WB));
  // An unexpected access inside a burst is re-judged as a fresh burst start.
  assign restart    = mactive & (~busy | ~expected);
  assign burst_end  = busy & mactive & expected & (cnt == LAST);
  assign single_end = (WORDS == 1) & restart & (off == '0);
  assign done_now   = burst_end | single_end;
  assign done_wb    = burst_end ? (state == WB) : mwrite_en;

  assign err_set = (mactive & (~in_range | (maddr[1:0] != 2'b00))) | collide
                 | (busy & ~mactive) | (busy & mactive & ~expected)
                 | (restart & (off != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      line_done    <= 1'b0;
      line_is_wb   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      line_done <= done_now;
      if (done_now) line_is_wb   <= done_wb;
      if (err_set)  protocol_err <= 1'b1;
      if (busy && !mactive) begin
        state <= IDLE;
      end else if (expected) begin
        if (cnt == LAST) state <= IDLE;
        else             cnt   <= cnt + 1'b1;
      end else if (restart) begin
        if (off != '0 || WORDS == 1) begin
          state <= IDLE;
        end else begin
          state <= mwrite_en ? WB : FILL;
          base  <= line_a;
          cnt   <= CW'(1);
        end
      end
    end
  end

`ifdef MEM_STATS_EN
  // Saturating so a long run never wraps back to a misleadingly small count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt <= '0;
      wb_cnt   <= '0;
    end else if (done_now) begin
      if (done_wb) begin
        if (wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
      end else begin
        if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed and randomized bench for cache_mem_responder (LINE_WIDTH=4, 4-word lines, 1024-word RAM).
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        reset, mactive, mwrite_en, load_en;
  logic [31:0] maddr, mdata, load_data, mout;
  logic [9:0]  load_addr;
  logic        line_done, line_is_wb, protocol_err;
`ifdef MEM_STATS_EN
  logic [15:0] fill_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  cache_mem_responder #(.ADDR_WIDTH(10), .LINE_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mactive(mactive), .mwrite_en(mwrite_en),
    .maddr(maddr), .mdata(mdata), .mout(mout),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .line_done(line_done), .line_is_wb(line_is_wb), .protocol_err(protocol_err)
`ifdef MEM_STATS_EN
    , .fill_cnt(fill_cnt), .wb_cnt(wb_cnt)
`endif
  );

  // Reference model: memory image plus a record of the currently open line transfer.
  logic [31:0] mm [0:1023];
  logic        open_b, open_wr;
  logic [31:0] open_line;
  int          open_next;
  logic        m_wb, m_err;
  int          m_fills, m_wbs;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input logic exp_done);
    chk("line_done", 32'(line_done), 32'(exp_done));
    chk("line_is_wb", 32'(line_is_wb), 32'(m_wb));
    chk("protocol_err", 32'(protocol_err), 32'(m_err));
`ifdef MEM_STATS_EN
    chk("fill_cnt", 32'(fill_cnt), 32'(m_fills));
    chk("wb_cnt", 32'(wb_cnt), 32'(m_wbs));
`endif
  endtask

  // One clock cycle of traffic; called and returns at posedge+1.
  task automatic step(input logic act, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic le, input logic [9:0] la, input logic [31:0] ld);
    logic        inr, done;
    int          off;
    logic [31:0] ln;
    mactive = act; mwrite_en = we; maddr = a; mdata = d;
    load_en = le; load_addr = la; load_data = ld;
    @(negedge clk);
    inr = ((a >> 12) == 32'd0);
    chk("mout", mout, inr ? mm[a[11:2]] : 32'd0);
    done = 1'b0;
    if (act && (!inr || a[1:0] != 2'b00)) m_err = 1'b1;
    if (le && act && we && inr) m_err = 1'b1;
    off = int'((a >> 2) & 32'd3);
    ln  = a >> 4;
    if (act) begin
      if (open_b && ln == open_line && off == open_next && we == open_wr) begin
        open_next++;
        if (open_next == 4) begin done = 1'b1; open_b = 1'b0; end
      end else begin
        if (open_b) begin m_err = 1'b1; open_b = 1'b0; end
        if (off == 0) begin
          open_b = 1'b1; open_wr = we; open_line = ln; open_next = 1;
        end else m_err = 1'b1;
      end
    end else if (open_b) begin
      m_err = 1'b1; open_b = 1'b0;
    end
    if (done) begin
      m_wb = open_wr;
      if (open_wr) m_wbs = (m_wbs < 65535) ? m_wbs + 1 : m_wbs;
      else         m_fills = (m_fills < 65535) ? m_fills + 1 : m_fills;
    end
    if (le) mm[la] = ld;
    else if (act && we && inr) mm[a[11:2]] = d;
    @(posedge clk); #1;
    chk_outs(done);
  endtask

  task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, we, a, d, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic idle(input logic [31:0] a);
    step(1'b0, 1'b0, a, 32'd0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic burst(input logic we, input logic [31:0] b, input logic [31:0] d0);
    for (int j = 0; j < 4; j++) acc(we, b + 32'(4 * j), d0 + 32'(j));
  endtask

  task automatic do_reset();
    mactive = 1'b0; mwrite_en = 1'b0; load_en = 1'b0;
    reset = 1'b0;
    #1;
    open_b = 1'b0; m_wb = 1'b0; m_err = 1'b0; m_fills = 0; m_wbs = 0;
    chk_outs(1'b0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  int          mode, bad, nw;
  logic        k, act, we, le;
  logic [31:0] a, b;
  logic [31:0] vals [0:3];

  initial begin
    reset = 1'b0; mactive = 1'b0; mwrite_en = 1'b0; maddr = 32'd0; mdata = 32'd0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 32'd0;
    open_b = 1'b0; open_wr = 1'b0; open_line = 32'd0; open_next = 0;
    m_wb = 1'b0; m_err = 1'b0; m_fills = 0; m_wbs = 0;
    for (int i = 0; i < 1024; i++) begin
      load_en = 1'b1; load_addr = 10'(i); load_data = $urandom; mm[i] = load_data;
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    do_reset();

    // Loader preload then an aligned fill reads the words back in the same cycle.
    vals[0] = 32'd11; vals[1] = 32'd22; vals[2] = 32'd33; vals[3] = 32'd44;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 10'(i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      acc(1'b0, 32'(4 * i), 32'd0);
      chk("t1_mout", mout, 32'(11 * (i + 1)));
    end
    chk("t1_done", 32'(line_done), 32'd1);
    chk("t1_is_wb", 32'(line_is_wb), 32'd0);

    // Write-back followed back-to-back by a fill, then re-read.
    burst(1'b1, 32'hA0, 32'd1);
    chk("t2_wb_done", 32'(line_done), 32'd1);
    chk("t2_wb_flag", 32'(line_is_wb), 32'd1);
    burst(1'b0, 32'h40, 32'd0);
    chk("t2_fill_flag", 32'(line_is_wb), 32'd0);
    chk("t2_no_err", 32'(protocol_err), 32'd0);
    idle(32'hA4);
    chk("t2_reread", mout, 32'd2);

    // Fill starting mid-line is rejected; error sticks; FSM still accepts a clean fill.
    acc(1'b0, 32'h8, 32'd0);
    chk("t3_err", 32'(protocol_err), 32'd1);
    idle(32'h0);
    chk("t3_sticky", 32'(protocol_err), 32'd1);
    burst(1'b0, 32'h0, 32'd0);
    chk("t3_idle_ok", 32'(line_done), 32'd1);
    do_reset();

    // Aborted fill, then a clean fill.
    acc(1'b0, 32'h100, 32'd0);
    acc(1'b0, 32'h104, 32'd0);
    idle(32'h100);
    chk("t4_abort_err", 32'(protocol_err), 32'd1);
    chk("t4_no_done", 32'(line_done), 32'd0);
    burst(1'b0, 32'h100, 32'd0);
    chk("t4_refill", 32'(line_done), 32'd1);
    do_reset();

    // Loader/cache write collision on one word.
    step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 10'd4, 32'h5A5A_0001);
    chk("t5_err", 32'(protocol_err), 32'd1);
    idle(32'h10);
    chk("t5_word", mout, 32'h5A5A_0001);
    do_reset();

    // Reset mid write-back, and reset right as a line_done pulse is showing.
    acc(1'b1, 32'h200, 32'd7);
    acc(1'b1, 32'h204, 32'd8);
    do_reset();
    burst(1'b1, 32'h300, 32'd9);
    chk("t6_pulse", 32'(line_done), 32'd1);
    do_reset();
    burst(1'b0, 32'h0, 32'd0);
    burst(1'b1, 32'h50, 32'd3);
    burst(1'b0, 32'h60, 32'd0);
    burst(1'b1, 32'h70, 32'd5);
    burst(1'b0, 32'h80, 32'd0);
`ifdef MEM_STATS_EN
    chk("t6_fill_cnt", 32'(fill_cnt), 32'd3);
    chk("t6_wb_cnt", 32'(wb_cnt), 32'd2);
`endif
    chk("t6_clean", 32'(protocol_err), 32'd0);

    // Randomized bursts with occasional injected protocol faults.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      mode = int'($urandom_range(0, 9));
      bad  = int'($urandom_range(0, 3));
      k    = 1'($urandom_range(0, 1));
      b    = 32'($urandom_range(0, 255)) << 4;
      nw   = (mode == 7) ? bad : 4;
      for (int j = 0; j < nw; j++) begin
        a = b + 32'(4 * j); act = 1'b1; we = k; le = 1'b0;
        if (j == bad) begin
          case (mode)
            1: a = b + 32'(4 * $urandom_range(0, 3));
            2: act = 1'b0;
            3: we = ~k;
            4: a = a | (32'd1 << $urandom_range(12, 31));
            5: a = a | 32'($urandom_range(1, 3));
            6: le = 1'b1;
            default: ;
          endcase
        end
        step(act, we, a, $urandom, le, 10'($urandom_range(0, 1023)), $urandom);
      end
      repeat ($urandom_range(0, 2)) begin
        a = ($urandom_range(0, 15) == 0) ? 32'h0001_0000 : 32'($urandom_range(0, 1023)) << 2;
        step(1'b0, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
